mux_arb_reg: RTL

// - Parametrised N-channel, WIDTH-bit multiplexer with built-in arbitration, valid/ready handshake and one output register.
// - Replaces hard-wired 2:1/4:1 selects where several producers compete for one consumer.
// - Used for memory-port and writeback sharing on the 8-bit datapath.
// - Selection is made by the arbiter each cycle; it is not a select input.

---
 rtl/mux_arb_reg.sv | 100 ++++++++++
 1 files changed

// File: rtl/mux_arb_reg.sv
// mux_arb_reg
//   N-channel, WIDTH-bit arbitrated multiplexer with a valid/ready handshake
//   on both sides and a single output register. The arbiter picks one
//   requesting channel per cycle (round-robin or fixed priority), and the
//   accepted beat lands in the output register one cycle later.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   per-channel request, bit k = channel k
//   in_data    channel k data at [k*WIDTH +: WIDTH]
//   in_ready   one-hot-or-zero accept strobe (combinational)
//   out_valid  output register holds a beat
//   out_data   data of the held beat
//   out_sel    index of the channel that supplied out_data
//   out_ready  consumer takes the beat when out_valid && out_ready
module mux_arb_reg #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int RR    = 1,
  parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  start;
  logic [SELW-1:0]  gsel;
  logic [WIDTH-1:0] gdata;
  logic [NCH-1:0]   grant;
  logic             any_grant;
  logic             load_en;

  // The register can take a new beat when it is empty or being drained now.
  assign load_en = !out_valid || out_ready;

  // Scan channels starting at the priority pointer; the first requester wins.
  // The explicit modulo lets a non-power-of-2 NCH wrap correctly.
  always_comb begin
    int idx;
    // NOTE: every variable gets a default before any conditional logic, so
    // no path leaves a value unassigned and no latch is inferred.
    idx       = 0;
    grant     = '0;
    gsel      = '0;
    gdata     = '0;
    any_grant = 1'b0;
    start     = (RR != 0) ? rr_ptr : '0;
    // No accept strobes while reset is held, even though the register is empty.
    if (load_en && !reset) begin
      for (int i = 0; i < NCH; i++) begin
        idx = int'(start) + i;
        if (idx >= NCH) idx = idx - NCH;
        if (!any_grant && in_valid[idx]) begin
          any_grant  = 1'b1;
          grant[idx] = 1'b1;
          gsel       = SELW'(idx);
          gdata      = in_data[idx*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign in_ready = grant;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: everything here is a control or datapath register (no memory
      // array), so all of it is cleared on reset.
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      if (any_grant) begin
        out_valid <= 1'b1;
        out_data  <= gdata;
        out_sel   <= gsel;
        // Pointer moves only on a transfer, to the channel after the winner.
        if (RR != 0) rr_ptr <= (gsel == LAST_CH) ? '0 : gsel + SELW'(1);
      end else begin
        // Drain with nothing to load: data and sel keep their old values.
        out_valid <= 1'b0;
      end
    end
  end

endmodule
